// File: rtl/key_entry_ctrl.sv
// Keypad digit-entry sequencer: edge-detects keys and shifts BCD digits
// into an NDIG-digit buffer, locking the value on enter.
package key_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } ke_state_e;

endpackage

module key_entry_ctrl
    import key_entry_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        keys,
    input  logic              key_clr,
    input  logic              key_ent,
    output logic [4*NDIG-1:0] digits,
    output logic [3:0]        digit_cnt,
    output logic              value_valid,
    output logic              locked,
    output logic              err
);

    localparam int         DW      = 4 * NDIG;
    localparam logic [3:0] CNT_MAX = 4'(NDIG);

    ke_state_e   state_q, state_d;

    logic [9:0]  keys_q, keys_d;
    logic        clr_q, clr_d;
    logic        ent_q, ent_d;

    logic [DW-1:0] digits_q, digits_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;

    logic [9:0]  rise;
    logic [3:0]  n_rise;
    logic [3:0]  dig_idx;
    logic        dig_ev;
    logic        multi_ev;
    logic        clr_ev;
    logic        ent_ev;

    logic        do_clr;
    logic        do_ent;
    logic        do_dig;
    logic        do_multi;
    logic        full;

    // Key history simply follows the level inputs every cycle
    always_comb begin
        keys_d = keys;
        clr_d  = key_clr;
        ent_d  = key_ent;
    end

    // Rising-edge detection and one-hot / multi-key classification
    always_comb begin
        rise    = keys & ~keys_q;
        n_rise  = '0;
        dig_idx = '0;
        for (int i = 0; i < 10; i++) begin
            if (rise[i]) begin
                n_rise  = n_rise + 4'd1;
                dig_idx = 4'(i);
            end
        end
        dig_ev   = (n_rise == 4'd1);
        multi_ev = (n_rise > 4'd1);
        clr_ev   = key_clr & ~clr_q;
        ent_ev   = key_ent & ~ent_q;
    end

    // Priority resolution: clear beats enter beats digit/multi
    always_comb begin
        do_clr   = clr_ev;
        do_ent   = ent_ev & ~clr_ev;
        do_dig   = dig_ev & ~clr_ev & ~ent_ev;
        do_multi = multi_ev & ~clr_ev & ~ent_ev;
        full     = (cnt_q == CNT_MAX);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (do_dig) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                unique case (1'b1)
                    do_clr:  state_d = ST_IDLE;
                    do_ent:  state_d = ST_DONE;
                    default: state_d = ST_ENTRY;
                endcase
            end
            ST_DONE: begin
                unique case (1'b1)
                    do_clr:  state_d = ST_IDLE;
                    do_dig:  state_d = ST_ENTRY;
                    default: state_d = ST_DONE;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        digits_d = digits_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = (state_d == ST_DONE);
        unique case (1'b1)
            do_clr: begin
                digits_d = '0;
                cnt_d    = '0;
            end
            do_ent: begin
                valid_d = (state_q == ST_ENTRY);
            end
            do_dig: begin
                if (state_q != ST_ENTRY) begin
                    digits_d = DW'(dig_idx);
                    cnt_d    = 4'd1;
                end else if (!full) begin
                    digits_d = (digits_q << 4) | DW'(dig_idx);
                    cnt_d    = cnt_q + 4'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
            do_multi: begin
                err_d = 1'b1;
            end
            default: begin
                err_d = 1'b0;
            end
        endcase
    end

    // Key history and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_q   <= '0;
            clr_q    <= 1'b0;
            ent_q    <= 1'b0;
            digits_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            keys_q   <= keys_d;
            clr_q    <= clr_d;
            ent_q    <= ent_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_cnt   = cnt_q;
    assign value_valid = valid_q;
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: directed vector table,
// reset corner cases and randomized traffic against a queue-based model.
module tb_key_entry_ctrl;

    localparam int NDIG = 4;
    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_DONE  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  keys = '0;
    logic        key_clr = 1'b0;
    logic        key_ent = 1'b0;
    logic [15:0] digits;
    logic [3:0]  digit_cnt;
    logic        value_valid;
    logic        locked;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    key_entry_ctrl #(.NDIG(NDIG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys        (keys),
        .key_clr     (key_clr),
        .key_ent     (key_ent),
        .digits      (digits),
        .digit_cnt   (digit_cnt),
        .value_valid (value_valid),
        .locked      (locked),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  k;
        logic        c;
        logic        e;
        logic [15:0] xd;
        logic [3:0]  xn;
        logic        xv;
        logic        xl;
        logic        xe;
    } vec_t;

    vec_t tbl[$];

    // model state
    logic [9:0] m_pk;
    logic       m_pc;
    logic       m_pe;
    int         m_mode;
    int         m_buf[$];

    function automatic vec_t mk(logic [9:0] k, logic c, logic e,
                                logic [15:0] xd, logic [3:0] xn,
                                logic xv, logic xl, logic xe);
        vec_t v;
        v.k = k; v.c = c; v.e = e;
        v.xd = xd; v.xn = xn; v.xv = xv; v.xl = xl; v.xe = xe;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] xd,
                         input logic [3:0] xn, input logic xv,
                         input logic xl, input logic xe);
        n_tests++;
        if (digits !== xd || digit_cnt !== xn || value_valid !== xv ||
            locked !== xl || err !== xe) begin
            n_fail++;
            $display("FAIL %s: got d=%h n=%0d v=%b l=%b e=%b, expected d=%h n=%0d v=%b l=%b e=%b",
                     name, digits, digit_cnt, value_valid, locked, err,
                     xd, xn, xv, xl, xe);
        end
    endtask

    task automatic step(input logic [9:0] k, input logic c, input logic e);
        keys = k; key_clr = c; key_ent = e;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pk = '0; m_pc = 1'b0; m_pe = 1'b0;
        m_mode = M_IDLE;
        m_buf.delete();
    endtask

    // Behavioural rules applied to one sampled cycle of inputs
    task automatic model_step(input logic [9:0] k, input logic c, input logic e,
                              output logic [15:0] xd, output logic [3:0] xn,
                              output logic xv, output logic xl, output logic xe);
        logic [9:0] rise;
        int n;
        int d;
        rise = k & ~m_pk;
        n = $countones(rise);
        d = 0;
        for (int i = 0; i < 10; i++) if (rise[i]) d = i;
        xv = 1'b0;
        xe = 1'b0;
        if (c && !m_pc) begin
            m_buf.delete();
            m_mode = M_IDLE;
        end else if (e && !m_pe) begin
            if (m_mode == M_ENTRY) begin
                m_mode = M_DONE;
                xv = 1'b1;
            end
        end else if (n == 1) begin
            if (m_mode == M_ENTRY && m_buf.size() == NDIG) begin
                xe = 1'b1;
            end else begin
                if (m_mode != M_ENTRY) m_buf.delete();
                m_buf.push_back(d);
                m_mode = M_ENTRY;
            end
        end else if (n >= 2) begin
            xe = 1'b1;
        end
        m_pk = k; m_pc = c; m_pe = e;
        xd = '0;
        foreach (m_buf[i]) xd = xd * 16 + 16'(m_buf[i]);
        xn = 4'(m_buf.size());
        xl = (m_mode == M_DONE);
    endtask

    initial begin
        logic [15:0] xd;
        logic [3:0]  xn;
        logic        xv, xl, xe;
        logic [9:0]  k;
        logic        c, e;
        int          r;

        // Directed table: each row is one clock of inputs and the outputs after it
        tbl.push_back(mk(10'h002, 0, 0, 16'h0001, 1, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0001, 1, 0, 0, 0));
        tbl.push_back(mk(10'h004, 0, 0, 16'h0012, 2, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0012, 2, 0, 0, 0));
        tbl.push_back(mk(10'h008, 0, 0, 16'h0123, 3, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0123, 3, 0, 0, 0));
        tbl.push_back(mk(10'h010, 0, 0, 16'h1234, 4, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h1234, 4, 0, 0, 0));
        tbl.push_back(mk(10'h020, 0, 0, 16'h1234, 4, 0, 0, 1));
        tbl.push_back(mk(10'h000, 0, 0, 16'h1234, 4, 0, 0, 0));
        tbl.push_back(mk(10'h000, 1, 0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(10'h080, 0, 0, 16'h0007, 1, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0007, 1, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 1, 16'h0007, 1, 1, 1, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0007, 1, 0, 1, 0));
        tbl.push_back(mk(10'h000, 0, 1, 16'h0007, 1, 0, 1, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0007, 1, 0, 1, 0));
        tbl.push_back(mk(10'h006, 0, 0, 16'h0007, 1, 0, 1, 1));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0007, 1, 0, 1, 0));
        tbl.push_back(mk(10'h200, 0, 0, 16'h0009, 1, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0009, 1, 0, 0, 0));
        tbl.push_back(mk(10'h000, 1, 0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(10'h020, 0, 0, 16'h0005, 1, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0005, 1, 0, 0, 0));
        tbl.push_back(mk(10'h006, 0, 0, 16'h0005, 1, 0, 0, 1));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0005, 1, 0, 0, 0));
        tbl.push_back(mk(10'h100, 1, 0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(10'h003, 0, 0, 16'h0000, 0, 0, 0, 1));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 1, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0, 16'h0000, 0, 0, 0, 0));

        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 16'h0000, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].k, tbl[i].c, tbl[i].e);
            check($sformatf("vec%0d", i), tbl[i].xd, tbl[i].xn,
                  tbl[i].xv, tbl[i].xl, tbl[i].xe);
        end

        // key held through reset release counts as a press
        rst_n = 1'b0;
        keys = 10'h008;
        @(posedge clk);
        #1;
        check("held_in_reset", 16'h0000, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("held_key_press", 16'h0003, 1, 0, 0, 0);
        step(10'h000, 0, 0);
        step(10'h010, 0, 0);
        check("pre_async_rst", 16'h0034, 2, 0, 0, 0);

        // asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000, 0, 0, 0, 0);

        // randomized traffic against the model
        keys = '0; key_clr = 1'b0; key_ent = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      k = '0;
            else if (r < 80) k = 10'(1) << $urandom_range(0, 9);
            else if (r < 90) k = keys;
            else             k = 10'($urandom);
            c = ($urandom_range(0, 99) < 5);
            e = ($urandom_range(0, 99) < 10);
            model_step(k, c, e, xd, xn, xv, xl, xe);
            step(k, c, e);
            check($sformatf("rand%0d", cyc), xd, xn, xv, xl, xe);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
